stage_writeback: RTL and testbench
==================================

Name: stage_writeback

Overview:
Memory/writeback stage of the 3-stage RISC-V pipeline. It is the producing end of the decode stage's write-back interface and generates reg_writeW, rdW and wb_resultW for the register file and forwarding muxes. It latches execute-stage results, runs loads and stores over a valid/ready data-memory interface, and formats load data. It raises stallW to the hazard unit while a memory transaction is outstanding.

Parameters:
XLEN, 32 (from defines.v `XLEN), datapath width
ADDR_W, 32, data-memory byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
validM  in  1  execute-stage result valid
alu_outM  in  XLEN  ALU result or effective address
rs2_dataM  in  XLEN  store data (already forwarded)
pc_plus4M  in  XLEN  link value for JAL/JALR
rdM  in  5  destination register
reg_writeM  in  1  instruction writes rd
wb_selM  in  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU)
mem_accessM  in  1  load or store
is_storeM  in  1  store (valid only with mem_accessM)
funct3M  in  3  access size/sign
stallW  out  1  freeze upstream stages
reg_writeW  out  1  register file write enable
rdW  out  5  write address
wb_resultW  out  XLEN  write data / forwarding value
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
dmem_wdata  out  XLEN  store data, lane-replicated
dmem_wstrb  out  4  byte enables
dmem_resp_valid  in  1  load data valid (one cycle)
dmem_rdata  in  XLEN  load data word
misalignW  out  1  misaligned access pulse (see Optional Feature)

Behaviour:
- W register (validW, addr, store data, pc+4, rd, controls) loads from M inputs on a clk edge when !stallW and holds when stallW. validW loads validM.
- FSM states: IDLE, REQ, WAIT. On capture with validM & mem_accessM, next state = REQ; otherwise stays IDLE.
- REQ: dmem_req_valid=1. On ready: store goes to IDLE; load goes to WAIT. Request fields stay stable until accepted.
- WAIT: on dmem_resp_valid, write the formatted load result and go to IDLE. A response is never accepted in the same cycle as its request (minimum one cycle in WAIT).
- stallW = (state==REQ) | (state==WAIT & !dmem_resp_valid). stallW is combinational, so a new op is captured in the same cycle the load response arrives.
- Non-memory ops have 1-cycle latency: the value is written the cycle after capture, with wb_resultW chosen by wb_sel.
- reg_writeW = rdW!=0 & reg_writeW_q & validW, gated as follows:
  - non-mem op: state IDLE;
  - load: state WAIT & dmem_resp_valid;
  - store: never.
- A mem op held in W while in IDLE (already completed) never re-issues and never writes.
- rdW and wb_resultW are 0 whenever reg_writeW=0.
- Stores: SB gives wstrb = 1<<addr[1:0] with the byte replicated ×4. SH gives wstrb = 0011 or 1100 by addr[1], with the halfword replicated ×2. SW gives 1111.
- Loads: LB/LBU select the byte by addr[1:0], LH/LHU select the halfword by addr[1], then sign- or zero-extend. LW uses the whole word.
- Reset: state IDLE, validW=0, every output 0. Reset mid-transaction abandons the transaction; a late dmem_resp_valid in IDLE is ignored.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issues no request and the FSM stays IDLE.
  - No register write occurs.
  - misalignW pulses high for one cycle, the cycle after capture.
- Undefined:
  - misalignW is tied 0.
  - Half accesses use addr[1] only; word accesses ignore addr[1:0].

Decomposition:
- defines.v: WB_SEL_ALU/MEM/PC4 encodings, funct3 LB/LH/LW/LBU/LHU/SB/SH/SW, FSM state codes.
- Sub-module mem_lane_align (combinational): produces store wstrb/wdata and the load extract/extend result.

Test Plan:
- ADD result 0x0000_1234, rd=5, wb_sel=ALU → next cycle reg_writeW=1, rdW=5, wb_resultW=0x1234, stallW=0.
- LB addr 0x103, rdata 0x80_00_00_00, ready immediately, resp one cycle later → wb_resultW=0xFFFF_FF80, stallW high for 2 cycles.
- SH addr 0x102, data 0xABCD, ready held low 3 cycles → dmem_req_valid stable, wstrb=1100, wdata=0xABCD_ABCD, no reg write.
- JAL rd=1, pc_plus4M=0x44 → wb_resultW=0x44. The same op with rd=0 → reg_writeW=0.
- Reset asserted in WAIT, then resp_valid → state IDLE, no write, stallW=0.
- With MISALIGN_CHECK_EN, LW addr 0x2 → misalignW pulse, dmem_req_valid never asserted.

Source files
------------

// File: rtl/stage_writeback_pkg.sv
// Shared definitions for the memory/writeback stage: write-back select
// encodings, load/store funct3 codes, FSM state codes and the alignment
// helper used when MISALIGN_CHECK_EN is defined.
package stage_writeback_pkg;

    localparam int XLEN_DEF = 32;

    // Write-back source select (2'b11 is reserved and behaves as ALU)
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Memory transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } wb_state_e;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/stage_writeback_mem_lane_align.sv
// Byte-lane alignment for the data-memory port. Purely combinational:
// builds store byte enables and lane-replicated store data, and extracts
// and sign/zero-extends load data from the returned word.
module mem_lane_align
    import stage_writeback_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_result
);

    logic [7:0]  load_byte_s;
    logic [15:0] load_half_s;

    // Store lane steering: replicate the datum across lanes, enable the addressed ones
    always_comb begin
        wstrb = 4'b0000;
        wdata = {XLEN{1'b0}};
        case (funct3)
            F3_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {(XLEN/8){store_data[7:0]}};
            end
            F3_SH: begin
                if (addr_lo[1]) begin
                    wstrb = 4'b1100;
                end else begin
                    wstrb = 4'b0011;
                end
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            F3_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        load_byte_s = 8'h00;
        load_half_s = 16'h0000;
        case (addr_lo)
            2'b00:   load_byte_s = load_word[7:0];
            2'b01:   load_byte_s = load_word[15:8];
            2'b10:   load_byte_s = load_word[23:16];
            2'b11:   load_byte_s = load_word[31:24];
            default: load_byte_s = load_word[7:0];
        endcase
        if (addr_lo[1]) begin
            load_half_s = load_word[31:16];
        end else begin
            load_half_s = load_word[15:0];
        end
    end

    // Sign- or zero-extend the selected load datum
    always_comb begin
        load_result = load_word;
        case (funct3)
            F3_LB:   load_result = {{(XLEN-8){load_byte_s[7]}}, load_byte_s};
            F3_LBU:  load_result = {{(XLEN-8){1'b0}}, load_byte_s};
            F3_LH:   load_result = {{(XLEN-16){load_half_s[15]}}, load_half_s};
            F3_LHU:  load_result = {{(XLEN-16){1'b0}}, load_half_s};
            F3_LW:   load_result = load_word;
            default: load_result = load_word;
        endcase
    end

endmodule

// File: rtl/stage_writeback.sv
// Memory/writeback stage of the 3-stage RISC-V pipeline.
// Latches execute results into the W register, runs loads/stores over a
// valid/ready data-memory port, formats load data and drives the register
// file write port and forwarding value. stallW freezes upstream stages while
// a memory transaction is outstanding.
// Optional feature macro: MISALIGN_CHECK_EN (misaligned half/word accesses
// are suppressed and flagged on misalignW; otherwise misalignW is tied low).
module stage_writeback
    import stage_writeback_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validM,
    input  logic [XLEN-1:0]   alu_outM,
    input  logic [XLEN-1:0]   rs2_dataM,
    input  logic [XLEN-1:0]   pc_plus4M,
    input  logic [4:0]        rdM,
    input  logic              reg_writeM,
    input  logic [1:0]        wb_selM,
    input  logic              mem_accessM,
    input  logic              is_storeM,
    input  logic [2:0]        funct3M,
    output logic              stallW,
    output logic              reg_writeW,
    output logic [4:0]        rdW,
    output logic [XLEN-1:0]   wb_resultW,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              misalignW
);

    wb_state_e         state_r;
    wb_state_e         state_next_s;

    logic              valid_w_r;
    logic [XLEN-1:0]   addr_w_r;
    logic [XLEN-1:0]   sdata_w_r;
    logic [XLEN-1:0]   pc4_w_r;
    logic [4:0]        rd_w_r;
    logic              reg_write_w_r;
    logic [1:0]        wb_sel_w_r;
    logic              mem_access_w_r;
    logic              is_store_w_r;
    logic [2:0]        funct3_w_r;
    logic              misalign_w_r;

    logic              stall_s;
    logic              misalign_m_s;
    logic              start_mem_s;
    logic              write_en_s;
    logic              in_req_s;
    logic [XLEN-1:0]   result_s;
    logic [3:0]        lane_wstrb_s;
    logic [XLEN-1:0]   lane_wdata_s;
    logic [XLEN-1:0]   load_result_s;

`ifdef MISALIGN_CHECK_EN
    assign misalign_m_s = validM & mem_accessM & is_misaligned(funct3M, alu_outM[1:0]);
`else
    assign misalign_m_s = 1'b0;
`endif

    // A captured memory op only starts a transaction if it is aligned
    assign start_mem_s = validM & mem_accessM & ~misalign_m_s;
    assign in_req_s    = (state_r == ST_REQ);

    // Hold upstream while a request is pending or a load response is awaited
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = ~dmem_resp_valid;
            default: stall_s = 1'b0;
        endcase
    end

    assign stallW = stall_s;

    // Next-state logic; whenever the stage is not stalled a new op is captured
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_mem_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    if (is_store_w_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_resp_valid) begin
                    if (start_mem_s) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // W pipeline register: capture M inputs unless stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_w_r      <= 1'b0;
            addr_w_r       <= {XLEN{1'b0}};
            sdata_w_r      <= {XLEN{1'b0}};
            pc4_w_r        <= {XLEN{1'b0}};
            rd_w_r         <= 5'd0;
            reg_write_w_r  <= 1'b0;
            wb_sel_w_r     <= 2'b00;
            mem_access_w_r <= 1'b0;
            is_store_w_r   <= 1'b0;
            funct3_w_r     <= 3'b000;
            misalign_w_r   <= 1'b0;
        end else if (!stall_s) begin
            valid_w_r      <= validM;
            addr_w_r       <= alu_outM;
            sdata_w_r      <= rs2_dataM;
            pc4_w_r        <= pc_plus4M;
            rd_w_r         <= rdM;
            reg_write_w_r  <= reg_writeM;
            wb_sel_w_r     <= wb_selM;
            mem_access_w_r <= mem_accessM;
            is_store_w_r   <= is_storeM;
            funct3_w_r     <= funct3M;
            misalign_w_r   <= misalign_m_s;
        end
    end

    mem_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .funct3      (funct3_w_r),
        .addr_lo     (addr_w_r[1:0]),
        .store_data  (sdata_w_r),
        .load_word   (dmem_rdata),
        .wstrb       (lane_wstrb_s),
        .wdata       (lane_wdata_s),
        .load_result (load_result_s)
    );

    // Register-file write enable: ALU/link ops write the cycle after capture,
    // loads write on their response, stores and completed mem ops never write
    always_comb begin
        write_en_s = 1'b0;
        if (valid_w_r && reg_write_w_r && (rd_w_r != 5'd0)) begin
            if (!mem_access_w_r) begin
                write_en_s = (state_r == ST_IDLE);
            end else if (!is_store_w_r) begin
                write_en_s = (state_r == ST_WAIT) && dmem_resp_valid;
            end else begin
                write_en_s = 1'b0;
            end
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Write-back source select; reserved encoding falls back to the ALU value
    always_comb begin
        result_s = addr_w_r;
        case (wb_sel_w_r)
            WB_SEL_MEM: result_s = load_result_s;
            WB_SEL_PC4: result_s = pc4_w_r;
            WB_SEL_ALU: result_s = addr_w_r;
            default:    result_s = addr_w_r;
        endcase
    end

    // Write port outputs are forced to zero whenever no write happens
    always_comb begin
        reg_writeW = write_en_s;
        if (write_en_s) begin
            rdW        = rd_w_r;
            wb_resultW = result_s;
        end else begin
            rdW        = 5'd0;
            wb_resultW = {XLEN{1'b0}};
        end
    end

    // Request fields come straight from the held W register, so they stay
    // stable until accepted; outside REQ they read as zero
    always_comb begin
        dmem_req_valid = in_req_s;
        dmem_we        = in_req_s & is_store_w_r;
        if (in_req_s) begin
            dmem_addr = {addr_w_r[ADDR_W-1:2], 2'b00};
        end else begin
            dmem_addr = {ADDR_W{1'b0}};
        end
        if (in_req_s && is_store_w_r) begin
            dmem_wdata = lane_wdata_s;
            dmem_wstrb = lane_wstrb_s;
        end else begin
            dmem_wdata = {XLEN{1'b0}};
            dmem_wstrb = 4'b0000;
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign misalignW = misalign_w_r & valid_w_r;
`else
    assign misalignW = 1'b0;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Directed-vector bench for stage_writeback with hand-computed expectations.
module tb_stage_writeback;

    logic        clk;
    logic        rst;
    logic        validM;
    logic [31:0] alu_outM;
    logic [31:0] rs2_dataM;
    logic [31:0] pc_plus4M;
    logic [4:0]  rdM;
    logic        reg_writeM;
    logic [1:0]  wb_selM;
    logic        mem_accessM;
    logic        is_storeM;
    logic [2:0]  funct3M;
    logic        stallW;
    logic        reg_writeW;
    logic [4:0]  rdW;
    logic [31:0] wb_resultW;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        misalignW;

    int n_vec;
    int n_miss;

    stage_writeback dut (
        .clk             (clk),
        .rst             (rst),
        .validM          (validM),
        .alu_outM        (alu_outM),
        .rs2_dataM       (rs2_dataM),
        .pc_plus4M       (pc_plus4M),
        .rdM             (rdM),
        .reg_writeM      (reg_writeM),
        .wb_selM         (wb_selM),
        .mem_accessM     (mem_accessM),
        .is_storeM       (is_storeM),
        .funct3M         (funct3M),
        .stallW          (stallW),
        .reg_writeW      (reg_writeW),
        .rdW             (rdW),
        .wb_resultW      (wb_resultW),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_rdata      (dmem_rdata),
        .misalignW       (misalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                          input logic [1:0] sel, input logic mem, input logic st,
                          input logic [2:0] f3);
        validM      = v;
        alu_outM    = alu;
        rs2_dataM   = sd;
        pc_plus4M   = pc4;
        rdM         = rd;
        reg_writeM  = rw;
        wb_selM     = sel;
        mem_accessM = mem;
        is_storeM   = st;
        funct3M     = f3;
    endtask

    task automatic clear_op();
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    endtask

    // Load with ready on first REQ cycle and response on the second WAIT cycle
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_res);
        set_op(1'b1, addr, 32'h0, 32'h0, rd, 1'b1, 2'b01, 1'b1, 1'b0, f3);
        dmem_req_ready = 1'b1;
        step();
        clear_op();
        #1;
        check_vec({tag, "_req_valid"}, dmem_req_valid, 32'd1);
        check_vec({tag, "_stall_req"}, stallW, 32'd1);
        check_vec({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_vec({tag, "_we"}, dmem_we, 32'd0);
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_vec({tag, "_stall_wait"}, stallW, 32'd1);
        check_vec({tag, "_nowrite_wait"}, reg_writeW, 32'd0);
        step();
        dmem_resp_valid = 1'b1;
        dmem_rdata      = rdata;
        #1;
        check_vec({tag, "_stall_resp"}, stallW, 32'd0);
        check_vec({tag, "_wr"}, reg_writeW, 32'd1);
        check_vec({tag, "_rd"}, rdW, {27'd0, rd});
        check_vec({tag, "_data"}, wb_resultW, exp_res);
        step();
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 32'h0;
        #1;
        check_vec({tag, "_wr_after"}, reg_writeW, 32'd0);
    endtask

    // Store accepted immediately
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        set_op(1'b1, addr, data, 32'h0, 5'd4, 1'b1, 2'b00, 1'b1, 1'b1, f3);
        dmem_req_ready = 1'b1;
        step();
        clear_op();
        #1;
        check_vec({tag, "_req_valid"}, dmem_req_valid, 32'd1);
        check_vec({tag, "_we"}, dmem_we, 32'd1);
        check_vec({tag, "_strb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
        check_vec({tag, "_wdata"}, dmem_wdata, exp_wdata);
        check_vec({tag, "_nowrite"}, reg_writeW, 32'd0);
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_vec({tag, "_done_valid"}, dmem_req_valid, 32'd0);
        check_vec({tag, "_done_stall"}, stallW, 32'd0);
        check_vec({tag, "_done_nowrite"}, reg_writeW, 32'd0);
    endtask

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 32'h0;
        clear_op();
        step();
        step();
        #1;
        check_vec("rst_stall", stallW, 32'd0);
        check_vec("rst_wr", reg_writeW, 32'd0);
        check_vec("rst_rd", rdW, 32'd0);
        check_vec("rst_res", wb_resultW, 32'd0);
        check_vec("rst_req", dmem_req_valid, 32'd0);
        check_vec("rst_mis", misalignW, 32'd0);
        rst = 1'b0;
        step();

        // ADD -> ALU result written next cycle
        set_op(1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
        step();
        clear_op();
        #1;
        check_vec("add_wr", reg_writeW, 32'd1);
        check_vec("add_rd", rdW, 32'd5);
        check_vec("add_res", wb_resultW, 32'h0000_1234);
        check_vec("add_stall", stallW, 32'd0);
        step();
        check_vec("add_wr_gone", reg_writeW, 32'd0);

        // Reserved wb_sel behaves as ALU
        set_op(1'b1, 32'h0000_0077, 32'h0, 32'h0000_0088, 5'd6, 1'b1, 2'b11, 1'b0, 1'b0, 3'b000);
        step();
        clear_op();
        #1;
        check_vec("rsv_res", wb_resultW, 32'h0000_0077);

        // JAL link value, then same with rd=0
        set_op(1'b1, 32'h0000_0999, 32'h0, 32'h0000_0044, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000);
        step();
        clear_op();
        #1;
        check_vec("jal_wr", reg_writeW, 32'd1);
        check_vec("jal_rd", rdW, 32'd1);
        check_vec("jal_res", wb_resultW, 32'h0000_0044);
        set_op(1'b1, 32'h0000_0999, 32'h0, 32'h0000_0044, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000);
        step();
        clear_op();
        #1;
        check_vec("jal0_wr", reg_writeW, 32'd0);
        check_vec("jal0_rd", rdW, 32'd0);
        check_vec("jal0_res", wb_resultW, 32'd0);
        step();

        // Loads: sign/zero extension and lane selection
        do_load("lb",  32'h0000_0103, 3'b000, 5'd7,  32'h8000_0000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_0101, 3'b100, 5'd8,  32'h0000_9A00, 32'h0000_009A);
        do_load("lhu", 32'h0000_0102, 3'b101, 5'd9,  32'h8001_0000, 32'h0000_8001);
        do_load("lh",  32'h0000_0100, 3'b001, 5'd10, 32'h1234_F00F, 32'hFFFF_F00F);
        do_load("lw",  32'h0000_0104, 3'b010, 5'd11, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Stores with immediate accept
        do_store("sb", 32'h0000_0101, 3'b000, 32'h0000_0012, 4'b0010, 32'h1212_1212);
        do_store("sw", 32'h0000_0200, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // SH held off by ready low for 3 cycles; an ADD waits upstream meanwhile
        set_op(1'b1, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 5'd3, 1'b1, 2'b00, 1'b1, 1'b1, 3'b001);
        step();
        set_op(1'b1, 32'h0000_0055, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_vec("sh_req_valid", dmem_req_valid, 32'd1);
            check_vec("sh_strb", {28'd0, dmem_wstrb}, 32'h0000_000C);
            check_vec("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            check_vec("sh_addr", dmem_addr, 32'h0000_0100);
            check_vec("sh_stall", stallW, 32'd1);
            check_vec("sh_nowrite", reg_writeW, 32'd0);
            step();
        end
        dmem_req_ready = 1'b1;
        #1;
        check_vec("sh_acc_valid", dmem_req_valid, 32'd1);
        check_vec("sh_acc_we", dmem_we, 32'd1);
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_vec("sh_idle_req", dmem_req_valid, 32'd0);
        check_vec("sh_idle_stall", stallW, 32'd0);
        check_vec("sh_idle_nowrite", reg_writeW, 32'd0);
        step();
        clear_op();
        #1;
        check_vec("held_add_wr", reg_writeW, 32'd1);
        check_vec("held_add_rd", rdW, 32'd9);
        check_vec("held_add_res", wb_resultW, 32'h0000_0055);
        step();

        // Reset while waiting for a load response; late response is ignored
        set_op(1'b1, 32'h0000_0300, 32'h0, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        dmem_req_ready = 1'b1;
        step();
        clear_op();
        step();
        dmem_req_ready = 1'b0;
        #1;
        check_vec("rw_wait_stall", stallW, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 32'h1111_2222;
        #1;
        check_vec("rw_stall", stallW, 32'd0);
        check_vec("rw_wr", reg_writeW, 32'd0);
        check_vec("rw_res", wb_resultW, 32'd0);
        check_vec("rw_req", dmem_req_valid, 32'd0);
        step();
        dmem_resp_valid = 1'b0;
        #1;
        check_vec("rw_after_wr", reg_writeW, 32'd0);

        // Misaligned LW at 0x2
        set_op(1'b1, 32'h0000_0002, 32'h0, 32'h0, 5'd13, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        dmem_req_ready = 1'b0;
        step();
        clear_op();
        #1;
`ifdef MISALIGN_CHECK_EN
        check_vec("mis_pulse", misalignW, 32'd1);
        check_vec("mis_noreq", dmem_req_valid, 32'd0);
        check_vec("mis_nostall", stallW, 32'd0);
        check_vec("mis_nowrite", reg_writeW, 32'd0);
        step();
        check_vec("mis_pulse_end", misalignW, 32'd0);
        check_vec("mis_noreq2", dmem_req_valid, 32'd0);
`else
        check_vec("mis_tied", misalignW, 32'd0);
        check_vec("mis_req", dmem_req_valid, 32'd1);
        check_vec("mis_addr", dmem_addr, 32'h0000_0000);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 32'h0BAD_F00D;
        #1;
        check_vec("mis_lw_res", wb_resultW, 32'h0BAD_F00D);
        step();
        dmem_resp_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
